// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  imem_ready;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, IF/ID register and a one-entry skid buffer that
// absorbs the word returned in the cycle decode stalls.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    fetch_stage_if.master         imem,
    input  logic                  stall_d,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  misalign_err
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pc_f, skid_instr, skid_pc;
    logic                  flush, ready;

    assign imem.imem_req  = state == RUN;
    assign imem.imem_addr = pc_f;
    assign ready          = imem.imem_ready;
    assign flush          = redirect && state != IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    // Redirect in IDLE only reloads the PC, so it also suppresses a same-cycle trigger.
    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = RUN;
        else if (state == IDLE)
            state_nxt = (trigger && !redirect) ? RUN : IDLE;
        else if (state == RUN)
            state_nxt = (stall_d && ready) ? HOLD : RUN;
        else
            state_nxt = stall_d ? HOLD : RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f         <= RESET_PC;
            instr_d      <= NOP_INSTR;
            pc_d         <= '0;
            pc_plus4_d   <= '0;
            valid_d      <= 1'b0;
            skid_instr   <= '0;
            skid_pc      <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (redirect) begin
                pc_f <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
                if (|redirect_pc[1:0])
                    misalign_err <= 1'b1;
            end
            if (flush) begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end else if (state == HOLD && !stall_d) begin
                instr_d    <= skid_instr;
                pc_d       <= skid_pc;
                pc_plus4_d <= skid_pc + DATA_WIDTH'(4);
                valid_d    <= 1'b1;
            end else if (state == RUN) begin
                if (!stall_d) begin
                    valid_d <= ready;
                    instr_d <= ready ? imem.imem_rdata : NOP_INSTR;
                    if (ready) begin
                        pc_d       <= pc_f;
                        pc_plus4_d <= pc_f + DATA_WIDTH'(4);
                    end
                end else if (ready) begin
                    skid_instr <= imem.imem_rdata;
                    skid_pc    <= pc_f;
                end
                if (ready)
                    pc_f <= pc_f + DATA_WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a queue-based reference model.
module tb_fetch_stage;
    localparam logic [31:0] K   = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, trigger, stall_d, redirect;
    logic [31:0] redirect_pc, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign_err;
    int          n_cmp = 0, n_err = 0;

    fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    assign bus.imem_rdata = bus.imem_addr ^ K;

    fetch_stage dut (
        .clk(clk), .rst(rst), .trigger(trigger), .imem(bus), .stall_d(stall_d),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; trigger = 0; stall_d = 0; redirect = 0; redirect_pc = 0; bus.imem_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; trigger = 1; redirect = 1; redirect_pc = 32'h33; stall_d = 1;
        tick();
        idle_inputs();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, misalign_err} !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL reset_values: req=%b addr=%h v=%b instr=%h pc=%h pp4=%h err=%b required 0/0/0/13/0/0/0", bus.imem_req, bus.imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, misalign_err);
        end
        tick();
        n_cmp++;
        if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_req: got %b required 0", bus.imem_req); end
    endtask

    task automatic test_sequence();
        trigger = 1; bus.imem_ready = 1;
        tick();
        trigger = 0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, valid_d} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL run_start: req=%b addr=%h v=%b required 1/0/0", bus.imem_req, bus.imem_addr, valid_d);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({valid_d, instr_d, pc_d, pc_plus4_d} !== {1'b1, (32'(i * 4) ^ K), 32'(i * 4), 32'(i * 4 + 4)}) begin
                n_err++; $display("FAIL seq_%0d: v=%b instr=%h pc=%h pp4=%h required pc=%h", i, valid_d, instr_d, pc_d, pc_plus4_d, i * 4);
            end
        end
    endtask

    task automatic test_stall();
        idle_inputs(); rst = 1; tick(); rst = 0;
        trigger = 1; tick(); trigger = 0;
        bus.imem_ready = 1; tick(); tick();
        stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.imem_req, valid_d, pc_d} !== {1'b0, 1'b1, 32'h4}) begin
                n_err++; $display("FAIL stall_hold_%0d: req=%b v=%b pc=%h required 0/1/4", i, bus.imem_req, valid_d, pc_d);
            end
        end
        stall_d = 0;
        tick();
        n_cmp++;
        if ({valid_d, pc_d, instr_d} !== {1'b1, 32'h8, 32'h8 ^ K}) begin
            n_err++; $display("FAIL stall_release_8: v=%b pc=%h instr=%h required pc=8", valid_d, pc_d, instr_d);
        end
        tick();
        n_cmp++;
        if ({valid_d, pc_d, pc_plus4_d, bus.imem_addr} !== {1'b1, 32'hC, 32'h10, 32'h10}) begin
            n_err++; $display("FAIL stall_release_c: v=%b pc=%h pp4=%h addr=%h required pc=c", valid_d, pc_d, pc_plus4_d, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        stall_d = 1; bus.imem_ready = 1;
        tick();
        redirect = 1; redirect_pc = 32'h100;
        tick();
        redirect = 0;
        n_cmp++;
        if ({valid_d, instr_d, bus.imem_req, bus.imem_addr} !== {1'b0, NOP, 1'b1, 32'h100}) begin
            n_err++; $display("FAIL redirect_flush: v=%b instr=%h req=%b addr=%h required 0/13/1/100", valid_d, instr_d, bus.imem_req, bus.imem_addr);
        end
        stall_d = 0;
        tick();
        n_cmp++;
        if ({valid_d, pc_d} !== {1'b1, 32'h100}) begin
            n_err++; $display("FAIL redirect_target: v=%b pc=%h required 1/100", valid_d, pc_d);
        end
        tick();
        n_cmp++;
        if ({valid_d, pc_d} !== {1'b1, 32'h104}) begin
            n_err++; $display("FAIL redirect_next: v=%b pc=%h required 1/104", valid_d, pc_d);
        end
    endtask

    task automatic test_bubbles();
        redirect = 1; redirect_pc = 32'h10;
        tick();
        redirect = 0; bus.imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({valid_d, instr_d, bus.imem_addr} !== {1'b0, NOP, 32'h10}) begin
                n_err++; $display("FAIL bubble_%0d: v=%b instr=%h addr=%h required 0/13/10", i, valid_d, instr_d, bus.imem_addr);
            end
        end
        bus.imem_ready = 1;
        tick();
        n_cmp++;
        if ({valid_d, pc_d, instr_d} !== {1'b1, 32'h10, 32'h10 ^ K}) begin
            n_err++; $display("FAIL bubble_end: v=%b pc=%h instr=%h required pc=10", valid_d, pc_d, instr_d);
        end
    endtask

    task automatic test_misalign();
        n_cmp++;
        if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_clear: got %b required 0", misalign_err); end
        redirect = 1; redirect_pc = 32'h203; bus.imem_ready = 1;
        tick();
        redirect = 0;
        n_cmp++;
        if ({bus.imem_addr, misalign_err} !== {32'h200, 1'b1}) begin
            n_err++; $display("FAIL misalign_set: addr=%h err=%b required 200/1", bus.imem_addr, misalign_err);
        end
        tick();
        n_cmp++;
        if ({pc_d, valid_d} !== {32'h200, 1'b1}) begin n_err++; $display("FAIL misalign_fetch: pc=%h v=%b required 200/1", pc_d, valid_d); end
        tick(); tick();
        n_cmp++;
        if (misalign_err !== 1'b1) begin n_err++; $display("FAIL misalign_sticky: got %b required 1", misalign_err); end
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC; bus.imem_ready = 1;
        tick();
        redirect = 0;
        tick();
        n_cmp++;
        if ({pc_d, pc_plus4_d, valid_d} !== {32'hFFFF_FFFC, 32'h0, 1'b1}) begin
            n_err++; $display("FAIL wrap_top: pc=%h pp4=%h v=%b required fffffffc/0/1", pc_d, pc_plus4_d, valid_d);
        end
        tick();
        n_cmp++;
        if ({pc_d, pc_plus4_d} !== {32'h0, 32'h4}) begin n_err++; $display("FAIL wrap_zero: pc=%h pp4=%h required 0/4", pc_d, pc_plus4_d); end
        stall_d = 1;
        tick();
        n_cmp++;
        if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL wrap_hold: req=%b required 0", bus.imem_req); end
        rst = 1; trigger = 1; redirect = 1; redirect_pc = 32'h55;
        tick();
        idle_inputs();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, misalign_err} !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid_hold: req=%b addr=%h v=%b instr=%h pc=%h pp4=%h err=%b required 0/0/0/13/0/0/0", bus.imem_req, bus.imem_addr, valid_d, instr_d, pc_d, pc_plus4_d, misalign_err);
        end
        tick();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL post_reset_idle: req=%b addr=%h required 0/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_random();
        logic        running, m_valid, m_err;
        logic [31:0] pcf, m_pc, rp;
        logic [31:0] skid[$];
        running = 0; m_valid = 0; m_err = 0; pcf = 0; m_pc = 0;
        idle_inputs(); rst = 1; tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst            = $urandom_range(0, 199) == 0;
            trigger        = $urandom_range(0, 3) == 0;
            stall_d        = $urandom_range(0, 9) < 3;
            bus.imem_ready = $urandom_range(0, 9) < 7;
            redirect       = $urandom_range(0, 19) == 0;
            rp             = $urandom;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? rp : {rp[31:2], 2'b00};
            if (rst) begin
                running = 0; m_valid = 0; m_err = 0; pcf = 0; m_pc = 0; skid.delete();
            end else begin
                if (redirect && redirect_pc[1:0] != 2'b00) m_err = 1;
                if (!running) begin
                    if (redirect) pcf = {redirect_pc[31:2], 2'b00};
                    else if (trigger) running = 1;
                end else if (redirect) begin
                    pcf = {redirect_pc[31:2], 2'b00}; m_valid = 0; skid.delete();
                end else if (skid.size() != 0) begin
                    if (!stall_d) begin m_pc = skid.pop_front(); m_valid = 1; end
                end else if (!stall_d) begin
                    m_valid = bus.imem_ready;
                    if (bus.imem_ready) begin m_pc = pcf; pcf += 4; end
                end else if (bus.imem_ready) begin
                    skid.push_back(pcf); pcf += 4;
                end
            end
            tick();
            n_cmp++;
            if ({valid_d, instr_d} !== {m_valid, m_valid ? (m_pc ^ K) : NOP} || (m_valid && {pc_d, pc_plus4_d} !== {m_pc, m_pc + 32'd4})) begin
                n_err++; $display("FAIL rand_ifid c=%0d: v=%b instr=%h pc=%h pp4=%h required v=%b pc=%h", c, valid_d, instr_d, pc_d, pc_plus4_d, m_valid, m_pc);
            end
            n_cmp++;
            if ({bus.imem_req, bus.imem_addr} !== {running && skid.size() == 0, pcf}) begin
                n_err++; $display("FAIL rand_bus c=%0d: req=%b addr=%h required req=%b addr=%h", c, bus.imem_req, bus.imem_addr, running && skid.size() == 0, pcf);
            end
            n_cmp++;
            if (misalign_err !== m_err) begin n_err++; $display("FAIL rand_misalign c=%0d: got %b required %b", c, misalign_err, m_err); end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequence();
        test_stall();
        test_redirect_hold();
        test_bubbles();
        test_misalign();
        test_wrap_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, instruction driven on instr_d when no valid instruction is held.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port trigger  in  1  start fetching from IDLE.
REQ-007 SHALL have port imem_req  out  1  fetch request valid.
REQ-008 SHALL have port imem_addr  out  DATA_WIDTH  fetch address, equal to pc_f.
REQ-009 SHALL have port imem_rdata  in  DATA_WIDTH  instruction word, valid when imem_ready=1.
REQ-010 SHALL have port imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-011 SHALL have port stall_d  in  1  decode stage cannot accept a new instruction.
REQ-012 SHALL have port redirect  in  1  branch/jump taken; flush and reload PC.
REQ-013 SHALL have port redirect_pc  in  DATA_WIDTH  target address (PC_target or jump-return value).
REQ-014 SHALL have ports instr_d, pc_d, pc_plus4_d  out  DATA_WIDTH each  IF/ID register contents.
REQ-015 SHALL have port valid_d  out  1  IF/ID register holds a real instruction.
REQ-016 SHALL have port misalign_err  out  1  sticky flag, redirect_pc[1:0] was nonzero.

Function
REQ-017 SHALL implement states IDLE, RUN, HOLD.
REQ-018 IDLE: imem_req=0; trigger=1 -> RUN next cycle; pc_f unchanged.
REQ-019 RUN: imem_req=1, imem_addr=pc_f.
REQ-020 RUN, imem_ready=1, stall_d=0: IF/ID <= {imem_rdata, pc_f, pc_f+4}, valid_d<=1, pc_f<=pc_f+4.
REQ-021 RUN, imem_ready=0, stall_d=0: valid_d<=0, instr_d<=NOP_INSTR, pc_f held (bubble).
REQ-022 RUN, stall_d=1: IF/ID held; if imem_ready=1, imem_rdata and pc_f are captured in a one-entry skid buffer, pc_f<=pc_f+4, -> HOLD.
REQ-023 HOLD: imem_req=0; when stall_d=0, IF/ID <= skid entry with valid_d=1, skid cleared, -> RUN; while stall_d=1, all held.
REQ-024 Redirect SHALL have top priority in every state except IDLE: pc_f <= {redirect_pc[31:2],2'b00}, valid_d<=0, instr_d<=NOP_INSTR, skid cleared, state -> RUN; stall_d ignored that cycle.
REQ-025 redirect in IDLE SHALL load pc_f only; state stays IDLE.
REQ-026 redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1 until reset.
REQ-027 pc_f+4 SHALL wrap modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no error.
REQ-028 Latency: instruction at address A appears on instr_d one cycle after the cycle imem_ready=1 with imem_addr=A, absent stall.
REQ-029 imem_rdata SHALL be sampled only when imem_req=1 and imem_ready=1.
REQ-030 At most one instruction SHALL be in flight beyond IF/ID (skid depth 1); no instruction dropped or duplicated under any stall pattern.

Reset
REQ-031 rst=1 SHALL, at next edge: state=IDLE, pc_f=RESET_PC, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, skid empty, misalign_err=0.
REQ-032 rst SHALL override trigger, redirect and stall_d, including mid-HOLD; imem_req=0 in the cycle after reset.

Verification
REQ-033 Reset, trigger pulse, imem_ready=1, rdata=addr^32'hA5A5_A5A5 -> instr_d sequence for pc 0,4,8 with pc_plus4_d 4,8,C, valid_d=1 from cycle 2.
REQ-034 stall_d=1 for 3 cycles while imem_ready=1 at pc=8 -> IF/ID holds pc 4, state HOLD, imem_req=0; release -> pc_d=8 then 0xC, no gap or repeat.
REQ-035 redirect=1, redirect_pc=0x100 concurrent with stall_d=1 in HOLD -> next cycle valid_d=0, instr_d=0x13, skid empty; following cycle pc_d=0x100.
REQ-036 imem_ready low 2 cycles at pc=0x10 -> two bubbles (valid_d=0, instr_d=0x13), then pc_d=0x10.
REQ-037 redirect_pc=0x203 -> fetch address 0x200, misalign_err=1 held until rst.
REQ-038 redirect_pc=0xFFFF_FFFC -> pc_d=0xFFFF_FFFC, pc_plus4_d=0, next pc_d=0; rst asserted mid-HOLD -> all REQ-031 values next cycle.
